// File: rtl/brq_pkg.sv
// Shared writeback types: retiring-instruction class and the queue entry layout.
package brq_pkg;

    typedef enum logic [1:0] {
        WB_INSTR_LOAD  = 2'b00,
        WB_INSTR_STORE = 2'b01,
        WB_INSTR_OTHER = 2'b10
    } wb_instr_type_e;

    // Per-entry bookkeeping; write data lives in a separate XLEN-wide array.
    typedef struct packed {
        logic           valid;
        wb_instr_type_e instr_type;
        logic [31:0]    pc;
        logic           compressed;
        logic           perf_count;
        logic           we;
        logic           fp;
        logic [4:0]     waddr;
        logic           resp;
        logic           err;
    } wbq_entry_t;

    function automatic logic [31:0] reg_bit(logic [4:0] r);
        return 32'(1) << r;
    endfunction

endpackage

// File: rtl/brq_wbu_queue_if.sv
// ID/EX push, LSU response and register-file write bundle of the writeback queue.
interface brq_wbu_queue_if #(
    parameter int XLEN = 32
);
    logic                    en_wb_i;
    logic                    ready_wb_o;
    brq_pkg::wb_instr_type_e instr_type_wb_i;
    logic [31:0]             pc_id_i;
    logic                    instr_is_compressed_id_i;
    logic                    instr_perf_count_id_i;
    logic [4:0]              rf_waddr_id_i;
    logic [XLEN-1:0]         rf_wdata_id_i;
    logic                    rf_we_id_i;
    logic                    fp_dest_i;
    logic                    lsu_resp_valid_i;
    logic                    lsu_resp_err_i;
    logic [XLEN-1:0]         rf_wdata_lsu_i;
    logic                    rf_we_wb_o;
    logic [4:0]              rf_waddr_wb_o;
    logic [XLEN-1:0]         rf_wdata_wb_o;
    logic                    fp_rf_we_wb_o;
    logic [4:0]              fp_rf_waddr_wb_o;
    logic [XLEN-1:0]         fp_rf_wdata_wb_o;
    logic [31:0]             int_pending_o;
    logic [31:0]             fp_pending_o;
    logic                    outstanding_load_wb_o;
    logic                    outstanding_store_wb_o;
    logic                    instr_done_wb_o;
    logic [31:0]             pc_wb_o;
    logic                    perf_instr_ret_wb_o;
    logic                    perf_instr_ret_compressed_wb_o;

    modport slave (
        input  en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, fp_dest_i,
               lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        output ready_wb_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
               fp_rf_we_wb_o, fp_rf_waddr_wb_o, fp_rf_wdata_wb_o,
               int_pending_o, fp_pending_o, outstanding_load_wb_o, outstanding_store_wb_o,
               instr_done_wb_o, pc_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
    );

    modport master (
        output en_wb_i, instr_type_wb_i, pc_id_i, instr_is_compressed_id_i,
               instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i, fp_dest_i,
               lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
        input  ready_wb_o, rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
               fp_rf_we_wb_o, fp_rf_waddr_wb_o, fp_rf_wdata_wb_o,
               int_pending_o, fp_pending_o, outstanding_load_wb_o, outstanding_store_wb_o,
               instr_done_wb_o, pc_wb_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
    );
endinterface

// File: rtl/brq_wbu_queue.sv
// In-order multi-entry writeback queue: holds retiring ID/EX results until their
// LSU responses arrive, retires one per cycle and exports pending-write masks.
module brq_wbu_queue
    import brq_pkg::*;
#(
    parameter int Depth    = 2,
    parameter int XLEN     = 32,
    parameter bit FpEnable = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    brq_wbu_queue_if.slave wb
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    wbq_entry_t      ent_q [Depth];
    wbq_entry_t      ent_d [Depth];
    logic [XLEN-1:0] data_q[Depth];
    logic [XLEN-1:0] data_d[Depth];

    logic            resp_found, resp_hit, resp_hit_head;
    logic [PtrW-1:0] resp_idx;
    wbq_entry_t      head_e;
    logic            head_done, head_err, wr_en, push;
    logic [XLEN-1:0] wr_data;
    logic [31:0]     int_pend, fp_pend;
    logic            out_ld, out_st;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (int'(p) == Depth - 1) ? '0 : p + 1'b1;
    endfunction

    // LSU responses complete in order, so they belong to the oldest unanswered memory op.
    always_comb begin : oldest_unanswered
        int idx;
        resp_found = 1'b0;
        resp_idx   = head_q;
        idx        = 0;
        for (int i = 0; i < Depth; i++) begin
            idx = int'(head_q) + i;
            if (idx >= Depth) idx = idx - Depth;
            if (!resp_found && ent_q[PtrW'(idx)].valid && !ent_q[PtrW'(idx)].resp &&
                ent_q[PtrW'(idx)].instr_type != WB_INSTR_OTHER) begin
                resp_found = 1'b1;
                resp_idx   = PtrW'(idx);
            end
        end
    end

    always_comb begin
        head_e        = ent_q[head_q];
        resp_hit      = wb.lsu_resp_valid_i & resp_found;
        resp_hit_head = resp_hit & (resp_idx == head_q);
        head_done     = head_e.valid &
                        ((head_e.instr_type == WB_INSTR_OTHER) | head_e.resp | resp_hit_head);
        head_err      = resp_hit_head ? wb.lsu_resp_err_i : head_e.err;
        wr_data       = resp_hit_head ? wb.rf_wdata_lsu_i : data_q[head_q];
        wr_en         = head_done & head_e.we & ~head_err &
                        (head_e.instr_type != WB_INSTR_STORE);
        push          = wb.en_wb_i & wb.ready_wb_o;
    end

    always_comb begin
        int_pend = '0;
        fp_pend  = '0;
        out_ld   = 1'b0;
        out_st   = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (ent_q[PtrW'(i)].valid) begin
                if (ent_q[PtrW'(i)].we) begin
                    if (ent_q[PtrW'(i)].fp) fp_pend  = fp_pend  | reg_bit(ent_q[PtrW'(i)].waddr);
                    else                    int_pend = int_pend | reg_bit(ent_q[PtrW'(i)].waddr);
                end
                if (!ent_q[PtrW'(i)].resp) begin
                    if (ent_q[PtrW'(i)].instr_type == WB_INSTR_LOAD)  out_ld = 1'b1;
                    if (ent_q[PtrW'(i)].instr_type == WB_INSTR_STORE) out_st = 1'b1;
                end
            end
        end
    end

    // Retire frees the head slot before a same-cycle push may reuse it when full.
    always_comb begin
        ent_d   = ent_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (resp_hit && !resp_hit_head) begin
            ent_d[resp_idx].resp = 1'b1;
            ent_d[resp_idx].err  = wb.lsu_resp_err_i;
            data_d[resp_idx]     = wb.rf_wdata_lsu_i;
        end
        if (head_done) begin
            ent_d[head_q].valid = 1'b0;
            head_d              = ptr_inc(head_q);
        end
        if (push) begin
            ent_d[tail_q].valid      = 1'b1;
            ent_d[tail_q].instr_type = wb.instr_type_wb_i;
            ent_d[tail_q].pc         = wb.pc_id_i;
            ent_d[tail_q].compressed = wb.instr_is_compressed_id_i;
            ent_d[tail_q].perf_count = wb.instr_perf_count_id_i;
            ent_d[tail_q].we         = wb.rf_we_id_i;
            ent_d[tail_q].fp         = wb.fp_dest_i & FpEnable;
            ent_d[tail_q].waddr      = wb.rf_waddr_id_i;
            ent_d[tail_q].resp       = 1'b0;
            ent_d[tail_q].err        = 1'b0;
            data_d[tail_q]           = wb.rf_wdata_id_i;
            tail_d                   = ptr_inc(tail_q);
        end
        count_d = count_q + CntW'(push) - CntW'(head_done);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) ent_q[PtrW'(i)] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

    // Write data is only consumed behind a valid entry, so it needs no reset.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign wb.ready_wb_o       = (int'(count_q) < Depth) | head_done;
    assign wb.rf_we_wb_o       = wr_en & ~head_e.fp;
    assign wb.rf_waddr_wb_o    = wb.rf_we_wb_o ? head_e.waddr : '0;
    assign wb.rf_wdata_wb_o    = wb.rf_we_wb_o ? wr_data : '0;
    assign wb.fp_rf_we_wb_o    = FpEnable & wr_en & head_e.fp;
    assign wb.fp_rf_waddr_wb_o = wb.fp_rf_we_wb_o ? head_e.waddr : '0;
    assign wb.fp_rf_wdata_wb_o = wb.fp_rf_we_wb_o ? wr_data : '0;
    assign wb.int_pending_o    = int_pend;
    assign wb.fp_pending_o     = FpEnable ? fp_pend : '0;
    assign wb.outstanding_load_wb_o  = out_ld;
    assign wb.outstanding_store_wb_o = out_st;
    assign wb.instr_done_wb_o  = head_done;
    assign wb.pc_wb_o          = head_e.valid ? head_e.pc : '0;
    assign wb.perf_instr_ret_wb_o            = head_done & head_e.perf_count & ~head_err;
    assign wb.perf_instr_ret_compressed_wb_o = wb.perf_instr_ret_wb_o & head_e.compressed;

    stray_lsu_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wb.lsu_resp_valid_i |-> resp_found)
        else $error("LSU response with no unanswered load/store in the writeback queue");

endmodule
